// File: rtl/push_button_conditioner.sv
// Two-button conditioner: 2-flop sync, debounce FSM and press-edge detect per button,
// then arbitration so p1/p2 never fire together. Define PBC_LOCKOUT_EN to also block a press while the other button is held.
//
// state        | meaning
// IDLE         | released, debounced level 0
// PRESS_WAIT   | high seen, counting consecutive high samples
// PRESSED      | debounced level 1, press already strobed
// RELEASE_WAIT | low seen, counting consecutive low samples
module push_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic p1,
    output logic p2,
    output logic btn1_level,
    output logic btn2_level,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       level;
    logic [1:0]       ev;
    state_t           state [2];
    logic [CNT_W-1:0] cnt   [2];
    logic             block1;
    logic             block2;

    assign raw        = {btn2_raw, btn1_raw};
    assign btn1_level = level[0];
    assign btn2_level = level[1];

    // Press event is the PRESS_WAIT -> PRESSED transition condition.
    always_comb begin
        ev = '0;
        for (int i = 0; i < 2; i++) begin
            ev[i] = (state[i] == PRESS_WAIT) && sync2[i] && (cnt[i] == CNT_TC);
        end
    end

`ifdef PBC_LOCKOUT_EN
    assign block1 = ev[0] && (ev[1] || level[1]);
    assign block2 = ev[1] && (ev[0] || level[0]);
`else
    assign block1 = ev[0] && ev[1];
    assign block2 = ev[1] && ev[0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            p1       <= 1'b0;
            p2       <= 1'b0;
            conflict <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            p1       <= ev[0] && !block1;
            p2       <= ev[1] && !block2;
            conflict <= block1 || block2;
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    IDLE: begin
                        if (sync2[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_TC) begin
                            state[i] <= PRESSED;
                            cnt[i]   <= '0;
                            level[i] <= 1'b1;
                        end else begin
                            cnt[i]   <= cnt[i] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!sync2[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2[i]) begin
                            state[i] <= PRESSED;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_TC) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                            level[i] <= 1'b0;
                        end else begin
                            cnt[i]   <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                        level[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner with DEBOUNCE_CYCLES=4.
module tb_push_button_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn1_raw = 1'b0;
    logic btn2_raw = 1'b0;
    logic p1, p2, btn1_level, btn2_level, conflict;

    int total = 0;
    int bad   = 0;
    int c1, c2, cc, both, lvl1_low, lvl1_high;

    push_button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn1_raw   (btn1_raw),
        .btn2_raw   (btn2_raw),
        .p1         (p1),
        .p2         (p2),
        .btn1_level (btn1_level),
        .btn2_level (btn2_level),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        c1 = 0; c2 = 0; cc = 0; both = 0; lvl1_low = 0; lvl1_high = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (p1) c1++;
            if (p2) c2++;
            if (conflict) cc++;
            if (p1 && p2) both++;
            if (!btn1_level) lvl1_low++;
            if (btn1_level) lvl1_high++;
        end
    endtask

    initial begin
        clear_counts();
        run(2);
        check("rst_p1", p1, 0);
        check("rst_p2", p2, 0);
        check("rst_lvl1", btn1_level, 0);
        check("rst_lvl2", btn2_level, 0);
        check("rst_conflict", conflict, 0);
        rst = 1'b1;
        run(3);

        // Single press: strobe after edge 6.
        btn1_raw = 1'b1;
        clear_counts();
        run(5);
        check("press_p1_e5", p1, 0);
        check("press_lvl1_e5", btn1_level, 0);
        run(1);
        check("press_p1_e6", p1, 1);
        check("press_lvl1_e6", btn1_level, 1);
        check("press_p2_e6", p2, 0);
        check("press_conf_e6", conflict, 0);
        run(1);
        check("press_p1_e7", p1, 0);
        run(10);
        check("press_p1_count", c1, 1);
        check("press_other", c2 + cc, 0);
        btn1_raw = 1'b0;
        clear_counts();
        run(5);
        check("release_lvl1_e5", btn1_level, 1);
        run(1);
        check("release_lvl1_e6", btn1_level, 0);
        run(4);
        check("release_no_strobe", c1, 0);

        // Three-cycle glitch is rejected.
        btn1_raw = 1'b1;
        clear_counts();
        run(3);
        btn1_raw = 1'b0;
        run(10);
        check("glitch_p1", c1, 0);
        check("glitch_lvl1", lvl1_high, 0);

        // Long hold with a two-cycle dropout at cycle 20.
        btn1_raw = 1'b1;
        clear_counts();
        run(10);
        check("hold_lvl1_up", btn1_level, 1);
        lvl1_low = 0;
        run(10);
        btn1_raw = 1'b0;
        run(2);
        btn1_raw = 1'b1;
        run(28);
        check("hold_one_strobe", c1, 1);
        check("hold_lvl1_never_low", lvl1_low, 0);
        btn1_raw = 1'b0;
        run(10);
        check("hold_released", btn1_level, 0);

        // Simultaneous presses: conflict only.
        btn1_raw = 1'b1;
        btn2_raw = 1'b1;
        clear_counts();
        run(5);
        check("same_conf_e5", conflict, 0);
        run(1);
        check("same_conf_e6", conflict, 1);
        check("same_p1_e6", p1, 0);
        check("same_p2_e6", p2, 0);
        run(1);
        check("same_conf_e7", conflict, 0);
        run(30);
        check("same_p1_total", c1, 0);
        check("same_p2_total", c2, 0);
        check("same_conf_total", cc, 1);
        check("same_lvl2", btn2_level, 1);
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        run(10);
        check("same_released", btn1_level + btn2_level, 0);

        // Button 2 pressed while button 1 held.
        btn1_raw = 1'b1;
        clear_counts();
        run(10);
        check("hold1_p1", c1, 1);
        btn2_raw = 1'b1;
        clear_counts();
        run(5);
        check("b2_p2_e5", p2, 0);
        run(1);
`ifdef PBC_LOCKOUT_EN
        check("b2_p2_e6", p2, 0);
        check("b2_conf_e6", conflict, 1);
`else
        check("b2_p2_e6", p2, 1);
        check("b2_conf_e6", conflict, 0);
`endif
        check("b2_lvl2_e6", btn2_level, 1);
        run(5);
        check("b2_never_both", both, 0);
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        run(10);

        // Reset in the middle of PRESS_WAIT.
        btn1_raw = 1'b1;
        clear_counts();
        run(4);
        rst = 1'b0;
        run(1);
        check("mid_rst_p1", p1, 0);
        check("mid_rst_lvl1", btn1_level, 0);
        check("mid_rst_conf", conflict, 0);
        rst = 1'b1;
        clear_counts();
        run(5);
        check("after_rst_e5", c1, 0);
        run(1);
        check("after_rst_p1_e6", p1, 1);
        check("after_rst_lvl1_e6", btn1_level, 1);
        btn1_raw = 1'b0;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/push_button_conditioner.md
Name: push_button_conditioner

Overview:
- Producer side of the push-button interface consumed by the light-system FSM. Takes two raw, asynchronous, bouncing buttons and drives the clean p1/p2 strobes that the FSM decodes.
- Per button: 2-flop synchronizer, debounce FSM and press-edge detector. A final arbitration stage guarantees that p1 and p2 are never asserted in the same cycle.
- Also exports debounced levels and a conflict strobe for status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples needed to accept a level change. Legal range 2..255.
- CNT_W, 8: debounce counter width. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- btn1_raw  input  1  raw button 1, asynchronous, active-high.
- btn2_raw  input  1  raw button 2, asynchronous, active-high.
- p1  output  1  one-cycle press strobe for button 1, registered.
- p2  output  1  one-cycle press strobe for button 2, registered.
- btn1_level  output  1  debounced level of button 1, registered.
- btn2_level  output  1  debounced level of button 2, registered.
- conflict  output  1  one-cycle strobe when a press was suppressed by arbitration.

Behaviour:
- Clock and reset: single clock domain (clk). rst is synchronous and active-low; it is sampled only on the clk rising edge.
- Reset state (rst=0 at an edge):
  - Synchronizer flops = 0.
  - Both FSMs in IDLE, counters = 0.
  - p1, p2, btn1_level, btn2_level, conflict = 0.
  - Reset has priority over every other event.
- Synchronizer: sync1 <= raw; sync2 <= sync1. The FSM uses only sync2.
- Per-button FSM. States: IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: sync2=1 -> PRESS_WAIT, cnt=1. Otherwise stay.
  - PRESS_WAIT:
    - sync2=0 -> IDLE, cnt=0 (bounce rejected, no strobe).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, raise press event.
    - Else cnt++.
  - PRESSED: sync2=0 -> RELEASE_WAIT, cnt=1. Otherwise stay.
  - RELEASE_WAIT:
    - sync2=1 -> PRESSED, cnt=0 (no new strobe).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0.
    - Else cnt++.
  - btn_level = 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT. It is registered together with the state.
- Latency: count the first edge that samples raw=1 as edge 1. If raw stays high, the press event occurs at edge DEBOUNCE_CYCLES+2, and p goes high for exactly one cycle after that edge. With the default of 4, that is edge 6.
  - A raw glitch shorter than DEBOUNCE_CYCLES cycles produces no strobe.
  - Release takes the same number of edges and produces no strobe.
- Holding: a button held indefinitely gives exactly one strobe. A new strobe requires a full debounced release first.
- Arbitration, applied at the edge the press events occur:
  - Only ev1 -> p1=1.
  - Only ev2 -> p2=1.
  - Both on the same edge -> p1=p2=0 and conflict=1 for one cycle. Both FSMs still advance to PRESSED, so neither button strobes again until it is released.
  - p1 && p2 is never 1.
- Reset mid-operation: all state is discarded. A button still held when rst returns high is treated as a new press, and its strobe follows the full latency from the first edge after reset.
- Counter does not wrap: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: PBC_LOCKOUT_EN.
- Defined: while either btn_level is 1, a press event on the other button is suppressed (p stays 0, conflict=1 for one cycle). That button's FSM still moves to PRESSED.
- Undefined: the only suppression is the same-edge case. A press of button 2 while button 1 is held produces p2 normally.

Test Plan:
- Reset, then btn1_raw=1 held from edge 1 (DEBOUNCE_CYCLES=4) -> p1=1 only in the cycle after edge 6; btn1_level=1 from edge 6; p2=conflict=0 throughout.
- btn1_raw pulsed high for 3 cycles, then low -> p1 stays 0 and btn1_level stays 0; FSM returns to IDLE.
- btn1_raw held for 50 cycles with a 2-cycle low glitch at cycle 20 -> exactly one p1 strobe; btn1_level never drops.
- btn1_raw and btn2_raw rise on the same edge and are held -> p1=p2=0, conflict=1 for one cycle after edge 6; no further strobes until both are released.
- btn1 held, then btn2 pressed 10 cycles later -> without PBC_LOCKOUT_EN: p2 strobe. With it: p2=0 and conflict=1 at btn2's press event.
- rst driven low for 1 cycle mid PRESS_WAIT while btn1_raw is held -> all outputs 0 at the next edge; p1 strobes at the 6th edge after rst returns high.
